// File: rtl/commit_unit_pkg.sv
// Shared widths and the retire-slot bundle for the commit unit.
package commit_unit_pkg;

   localparam int unsigned PW_W   = 5;
   localparam int unsigned RW_W   = 3;
   localparam int unsigned TYPE_W = 2;

   // Instruction type with no architectural destination.
   localparam logic [TYPE_W-1:0] TYPE_NODEST = 2'b11;

   // One ROB head slot as seen on the retire port.
   typedef struct packed {
      logic              ready;
      logic              excep;
      logic [TYPE_W-1:0] Type;
      logic [PW_W-1:0]   Pw;
      logic [PW_W-1:0]   Pw_old;
      logic [RW_W-1:0]   Rw;
   } retire_slot_t;

   // True when a slot of this type renames a destination register.
   function automatic logic has_dest(logic [TYPE_W-1:0] t);
      return t != TYPE_NODEST;
   endfunction

endpackage

// File: rtl/commit_unit_release.sv
// Release FIFO: circular buffer of freed physical registers, 3 pushes and 3 pops per cycle.
module release_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     push_cnt,
   input  logic [2:0][WIDTH-1:0]          push_data,
   input  logic                           pop,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic [2:0]                     valid,
   output logic [2:0][WIDTH-1:0]          data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W:0]   DEPTH_P = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, wr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, space;
   logic [1:0]       pop_n, push_n;

   // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] wrap_add(logic [PTR_W-1:0] p, logic [1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (PTR_W + 1)'(n);
      if (s >= DEPTH_P) s = s - DEPTH_P;
      return s[PTR_W-1:0];
   endfunction

   // Pop up to three, accept pushes only into free space; excess pushes are dropped.
   always_comb begin
      pop_n = 2'd0;
      if (pop) pop_n = (cnt_q >= CNT_W'(3)) ? 2'd3 : cnt_q[1:0];
      space  = DEPTH_C - cnt_q + CNT_W'(pop_n);
      push_n = (CNT_W'(push_cnt) > space) ? space[1:0] : push_cnt;
      cnt_d  = cnt_q + CNT_W'(push_n) - CNT_W'(pop_n);
   end

   // Storage writes; entries are only observable through valid-gated outputs.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < push_n) mem_q[wrap_add(wr_q, 2'(i))] <= push_data[i];
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= wrap_add(rd_q, pop_n);
         wr_q  <= wrap_add(wr_q, push_n);
         cnt_q <= cnt_d;
      end
   end

   // Head entries, zeroed when not present.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         valid[i] = cnt_q > CNT_W'(i);
         data[i]  = valid[i] ? mem_q[wrap_add(rd_q, 2'(i))] : '0;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/commit_unit.sv
// Commit unit: retires ROB head slots, maintains the aRAT, frees old registers, handles flush.
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int unsigned N_ARCH    = 8,
   parameter int unsigned N_PHYS    = 32,
   parameter int unsigned REL_DEPTH = 16,
   parameter int unsigned REL_HIWAT = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  ready_ret,
   input  logic [2:0]                  excep_ret,
   input  logic [2:0][TYPE_W-1:0]      Type_ret,
   input  logic [2:0][PW_W-1:0]        Pw_ret,
   input  logic [2:0][PW_W-1:0]        Pw_old_ret,
   input  logic [2:0][RW_W-1:0]        Rw_ret,
   input  logic                        ready_free,
   output logic [2:0]                  valid_free,
   output logic [2:0][PW_W-1:0]        Pw_free,
   output logic                        flush,
   output logic                        valid_recover,
   output logic [N_ARCH-1:0][PW_W-1:0] arch_map,
   output logic                        freeze_commit,
   output logic                        busy_recover,
   output logic [31:0]                 cnt_commit
);

   typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

   localparam int unsigned      CNT_W = $clog2(REL_DEPTH + 1);
   localparam logic [CNT_W-1:0] HIWAT = CNT_W'(REL_HIWAT);

   state_e                         state_q;
   logic                           flush_q, busy_q;
   retire_slot_t [2:0]             slot;
   logic [2:0]                     commit_mask;
   logic                           hit, chain_ok;
   logic [2:0]                     mask_q;
   logic [2:0][TYPE_W-1:0]         type_q;
   logic [2:0][RW_W-1:0]           rw_q;
   logic [2:0][PW_W-1:0]           pw_q, pw_old_q;
   logic [N_ARCH-1:0][PW_W-1:0]    arat_q, arat_d;
   logic [1:0]                     push_cnt;
   logic [2:0][PW_W-1:0]           push_data;
   logic [CNT_W-1:0]               rel_count;
   logic [31:0]                    cnt_q;

   // Bundle the retire port into per-slot records.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         slot[k].ready  = ready_ret[k];
         slot[k].excep  = excep_ret[k];
         slot[k].Type   = Type_ret[k];
         slot[k].Pw     = Pw_ret[k];
         slot[k].Pw_old = Pw_old_ret[k];
         slot[k].Rw     = Rw_ret[k];
      end
   end

   // In-order commit mask and first-exception detection; nothing retires outside RUN.
   always_comb begin
      commit_mask = '0;
      hit         = 1'b0;
      chain_ok    = (state_q == StRun);
      for (int k = 0; k < 3; k++) begin
         if (chain_ok && slot[k].ready && slot[k].excep) hit = 1'b1;
         chain_ok       = chain_ok && slot[k].ready && !slot[k].excep;
         commit_mask[k] = chain_ok;
      end
   end

   // Stage R: capture the committed slots for the apply step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mask_q   <= '0;
         type_q   <= '0;
         rw_q     <= '0;
         pw_q     <= '0;
         pw_old_q <= '0;
      end else begin
         mask_q <= commit_mask;
         for (int k = 0; k < 3; k++) begin
            type_q[k]   <= slot[k].Type;
            rw_q[k]     <= slot[k].Rw;
            pw_q[k]     <= slot[k].Pw;
            pw_old_q[k] <= slot[k].Pw_old;
         end
      end
   end

   // Apply step: aRAT writes in slot order (youngest wins) and compacted release pushes.
   always_comb begin
      arat_d    = arat_q;
      push_cnt  = 2'd0;
      push_data = '0;
      for (int k = 0; k < 3; k++) begin
         if (mask_q[k] && has_dest(type_q[k])) begin
            arat_d[rw_q[k]]     = pw_q[k];
            push_data[push_cnt] = pw_old_q[k];
            push_cnt            = push_cnt + 2'd1;
         end
      end
   end

   // Architectural map and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N_ARCH; i++) arat_q[i] <= PW_W'(i % N_PHYS);
         cnt_q <= '0;
      end else begin
         arat_q <= arat_d;
         cnt_q  <= cnt_q + 32'(mask_q[0]) + 32'(mask_q[1]) + 32'(mask_q[2]);
      end
   end

   // Recovery FSM: one-cycle FLUSH, then DRAIN until every old register is released.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StRun;
         flush_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hit) begin
                  state_q <= StFlush;
                  flush_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StFlush: begin
               state_q <= StDrain;
               flush_q <= 1'b0;
            end
            StDrain: begin
               if (rel_count == '0) begin
                  state_q <= StRun;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StRun;
               flush_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   release_fifo #(
      .DEPTH (REL_DEPTH),
      .WIDTH (PW_W)
   ) u_release_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop       (ready_free),
      .count     (rel_count),
      .valid     (valid_free),
      .data      (Pw_free)
   );

   // The map already reflects stage R so recovery sees the commits preceding the exception.
   assign arch_map      = arat_d;
   assign flush         = flush_q;
   assign valid_recover = flush_q;
   assign busy_recover  = busy_q;
   assign freeze_commit = (rel_count >= HIWAT) || busy_q;
   assign cnt_commit    = cnt_q;

endmodule

// File: tb/tb_commit_unit.sv
// Testbench for commit_unit: directed scenarios plus random traffic against a queue-based model.
module tb_commit_unit;
   import commit_unit_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [2:0]            ready_ret, excep_ret;
   logic [2:0][1:0]       Type_ret;
   logic [2:0][4:0]       Pw_ret, Pw_old_ret;
   logic [2:0][2:0]       Rw_ret;
   logic                  ready_free;
   logic [2:0]            valid_free;
   logic [2:0][4:0]       Pw_free;
   logic                  flush, valid_recover, freeze_commit, busy_recover;
   logic [7:0][4:0]       arch_map;
   logic [31:0]           cnt_commit;

   always #5 clk = ~clk;

   commit_unit dut (
      .clk           (clk),
      .rst           (rst),
      .ready_ret     (ready_ret),
      .excep_ret     (excep_ret),
      .Type_ret      (Type_ret),
      .Pw_ret        (Pw_ret),
      .Pw_old_ret    (Pw_old_ret),
      .Rw_ret        (Rw_ret),
      .ready_free    (ready_free),
      .valid_free    (valid_free),
      .Pw_free       (Pw_free),
      .flush         (flush),
      .valid_recover (valid_recover),
      .arch_map      (arch_map),
      .freeze_commit (freeze_commit),
      .busy_recover  (busy_recover),
      .cnt_commit    (cnt_commit)
   );

   // Reference model: committed map, pending commits (retired last cycle), free queue, mode.
   typedef struct {int rw; int pw; int pwold; bit nodest;} commit_t;
   localparam int M_NORMAL = 0, M_FLUSH = 1, M_DRAIN = 2;

   int          m_arat[8];
   int          m_fifo[$];
   commit_t     m_pend[$];
   int          m_mode;
   int unsigned m_cnt;
   int          n_pass = 0, n_total = 0, n_fail = 0;
   logic [7:0][4:0] ident;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_arat[i] = i;
      m_fifo.delete();
      m_pend.delete();
      m_mode = M_NORMAL;
      m_cnt  = 0;
   endtask

   function automatic logic [39:0] exp_map();
      int a[8];
      logic [39:0] r;
      a = m_arat;
      foreach (m_pend[i]) if (!m_pend[i].nodest) a[m_pend[i].rw] = m_pend[i].pw;
      for (int i = 0; i < 8; i++) r[i*5 +: 5] = 5'(a[i]);
      return r;
   endfunction

   task automatic check_outputs();
      logic [2:0]  ev;
      logic [14:0] ep;
      ev = '0;
      ep = '0;
      for (int i = 0; i < 3; i++) begin
         if (i < m_fifo.size()) begin
            ev[i] = 1'b1;
            ep[i*5 +: 5] = 5'(m_fifo[i]);
         end
      end
      check("arch_map", arch_map, exp_map());
      check("valid_free", valid_free, ev);
      check("Pw_free", Pw_free, ep);
      check("flush", flush, m_mode == M_FLUSH);
      check("valid_recover", valid_recover, m_mode == M_FLUSH);
      check("busy_recover", busy_recover, m_mode != M_NORMAL);
      check("freeze_commit", freeze_commit, (m_fifo.size() >= 10) || (m_mode != M_NORMAL));
      check("cnt_commit", cnt_commit, m_cnt);
   endtask

   task automatic model_update();
      int old_size;
      old_size = m_fifo.size();
      if (!rst) begin
         model_reset();
         return;
      end
      foreach (m_pend[i]) begin
         m_cnt++;
         if (!m_pend[i].nodest) m_arat[m_pend[i].rw] = m_pend[i].pw;
      end
      if (ready_free) begin
         for (int i = 0; i < 3 && m_fifo.size() > 0; i++) void'(m_fifo.pop_front());
      end
      foreach (m_pend[i]) begin
         if (!m_pend[i].nodest && m_fifo.size() < 16) m_fifo.push_back(m_pend[i].pwold);
      end
      m_pend.delete();
      case (m_mode)
         M_NORMAL: begin
            for (int k = 0; k < 3; k++) begin
               commit_t c;
               if (!ready_ret[k]) break;
               if (excep_ret[k]) begin
                  m_mode = M_FLUSH;
                  break;
               end
               c.rw = Rw_ret[k];
               c.pw = Pw_ret[k];
               c.pwold = Pw_old_ret[k];
               c.nodest = (Type_ret[k] == 2'b11);
               m_pend.push_back(c);
            end
         end
         M_FLUSH: m_mode = M_DRAIN;
         default: if (old_size == 0) m_mode = M_NORMAL;
      endcase
   endtask

   // One clock: check the current cycle at the falling edge, then step model on the rising edge.
   task automatic cycle();
      check_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_slots();
      ready_ret = '0; excep_ret = '0; Type_ret = '0;
      Pw_ret = '0; Pw_old_ret = '0; Rw_ret = '0;
   endtask

   task automatic set_slot(int k, bit rdy, bit exc, int rw, int pw, int pwold);
      ready_ret[k] = rdy; excep_ret[k] = exc; Type_ret[k] = 2'b00;
      Rw_ret[k] = 3'(rw); Pw_ret[k] = 5'(pw); Pw_old_ret[k] = 5'(pwold);
   endtask

   task automatic rand_slots(bit allow);
      bit chain;
      chain = allow;
      for (int k = 0; k < 3; k++) begin
         chain = chain && ($urandom_range(0, 3) != 0);
         ready_ret[k]  = chain;
         excep_ret[k]  = ($urandom_range(0, 15) == 0);
         Type_ret[k]   = 2'($urandom_range(0, 3));
         Rw_ret[k]     = 3'($urandom);
         Pw_ret[k]     = 5'($urandom);
         Pw_old_ret[k] = 5'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) ident[i] = 5'(i);
      clear_slots();
      ready_free = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      model_reset();
      @(negedge clk);

      // Reset and idle
      cycle();
      rst = 1'b1;
      check("reset_map", arch_map, ident);
      check("reset_cnt", cnt_commit, 0);
      cycle();

      // Three independent commits
      ready_free = 1'b1;
      set_slot(0, 1, 0, 1, 9, 1);
      set_slot(1, 1, 0, 2, 10, 2);
      set_slot(2, 1, 0, 3, 11, 3);
      cycle();
      clear_slots();
      check("map1", arch_map[1], 9);
      check("map2", arch_map[2], 10);
      check("map3", arch_map[3], 11);
      cycle();
      check("rel_valid", valid_free, 3'b111);
      check("rel0", Pw_free[0], 1);
      check("rel1", Pw_free[1], 2);
      check("rel2", Pw_free[2], 3);
      check("cnt3", cnt_commit, 3);

      // Same Rw in all three slots: youngest wins, all olds released
      set_slot(0, 1, 0, 4, 12, 20);
      set_slot(1, 1, 0, 4, 13, 21);
      set_slot(2, 1, 0, 4, 14, 22);
      cycle();
      clear_slots();
      check("map4_youngest", arch_map[4], 14);
      cycle();
      check("rel_same_rw", Pw_free, {5'd22, 5'd21, 5'd20});
      cycle();

      // Exception in slot 1 after slot 0 commits; later inputs are ignored
      ready_free = 1'b0;
      set_slot(0, 1, 0, 5, 15, 5);
      set_slot(1, 1, 1, 6, 16, 6);
      set_slot(2, 1, 0, 7, 17, 7);
      cycle();
      check("flush_hi", flush, 1);
      check("recover_hi", valid_recover, 1);
      check("flush_map5", arch_map[5], 15);
      set_slot(0, 1, 0, 6, 30, 30);
      set_slot(1, 1, 0, 6, 31, 31);
      cycle();
      check("flush_pulse", flush, 0);
      check("drain_busy", busy_recover, 1);
      cycle();
      cycle();
      check("ignored_map6", arch_map[6], 6);
      ready_free = 1'b1;
      for (int n = 0; n < 20 && busy_recover; n++) cycle();
      check("drain_done", busy_recover, 0);
      clear_slots();
      cycle();

      // Back-pressure: fill with ready_free low, then drain through the wrap point
      ready_free = 1'b0;
      for (int n = 0; n < 8; n++) begin
         clear_slots();
         if (m_fifo.size() < 10) begin
            for (int k = 0; k < 3; k++) set_slot(k, 1, 0, $urandom_range(0, 7), $urandom_range(0, 31), 3*n + k);
         end
         cycle();
      end
      check("freeze_hiwat", freeze_commit, 1);
      clear_slots();
      ready_free = 1'b1;
      for (int n = 0; n < 12 && m_fifo.size() > 0; n++) cycle();
      check("fifo_empty", valid_free, 3'b000);
      cycle();

      // Reset while draining
      ready_free = 1'b0;
      set_slot(0, 1, 0, 2, 17, 7);
      set_slot(1, 1, 1, 3, 18, 8);
      cycle();
      clear_slots();
      cycle();
      cycle();
      check("pre_reset_busy", busy_recover, 1);
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      check("rst_map", arch_map, ident);
      check("rst_busy", busy_recover, 0);
      check("rst_valid", valid_free, 3'b000);
      check("rst_flush", flush, 0);
      cycle();

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         bit fast;
         fast = ((n / 60) % 2) == 0;
         ready_free = fast ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
         rand_slots(m_fifo.size() < 10);
         rst = ($urandom_range(0, 299) != 0);
         cycle();
      end
      rst = 1'b1;
      clear_slots();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
